// File: rtl/dcache_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Interface : dcache_sram_arb_if
// Purpose   : Bundles the requester-side handshake (req/we/lock/addr/wdata in,
//             gnt/rvalid out) and the shared SRAM port driven by the arbiter.
// Modports  : slave  - the arbiter (consumes requests, drives grant + SRAM)
//             master - the requesters (drive requests, observe grant + SRAM)
// Signals   : req_i, we_i, lock_i [NR_PORTS]; addr_i [NR_PORTS*AW];
//             wdata_i [NR_PORTS*DW]; gnt_o, rvalid_o [NR_PORTS];
//             sram_req_o, sram_we_o, sram_addr_o [AW], sram_wdata_o [DW],
//             sram_sel_o [clog2(NR_PORTS)]
// Revision  : 1.0 - initial release
// ============================================================================
interface dcache_sram_arb_if #(
    parameter int NR_PORTS = 4,
    parameter int AW       = 12,
    parameter int DW       = 128
);
    localparam int c_SEL_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [NR_PORTS-1:0]    req_i;
    logic [NR_PORTS-1:0]    we_i;
    logic [NR_PORTS-1:0]    lock_i;
    logic [NR_PORTS*AW-1:0] addr_i;
    logic [NR_PORTS*DW-1:0] wdata_i;
    logic [NR_PORTS-1:0]    gnt_o;
    logic [NR_PORTS-1:0]    rvalid_o;
    logic                   sram_req_o;
    logic                   sram_we_o;
    logic [AW-1:0]          sram_addr_o;
    logic [DW-1:0]          sram_wdata_o;
    logic [c_SEL_W-1:0]     sram_sel_o;

    modport slave (
        input  req_i, we_i, lock_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, sram_req_o, sram_we_o, sram_addr_o,
               sram_wdata_o, sram_sel_o
    );

    modport master (
        output req_i, we_i, lock_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, sram_req_o, sram_we_o, sram_addr_o,
               sram_wdata_o, sram_sel_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_sram_arb.sv
`default_nettype none
// ============================================================================
// Module    : dcache_sram_arb
// Purpose   : Arbitrates NR_PORTS requesters (port 0 = miss handler, others =
//             PTW/load/store) onto the single data/tag/valid-dirty SRAM port.
//             Per-cycle priority: lock owner > starved port > port 0 >
//             round-robin over ports 1..N-1. Locks are bounded by LOCK_MAX
//             grants, after which the owner's lock_i is ignored until another
//             port is granted or the SRAM idles for a cycle.
// Ports     : clk_i, rst_i (sync, active-high)
//             bus (slave modport of dcache_sram_arb_if): requests in,
//             combinational one-hot grant + SRAM mux out, registered rvalid.
// Revision  : 1.0 - initial release
// ============================================================================
module dcache_sram_arb #(
    parameter int NR_PORTS = 4,
    parameter int AW       = 12,
    parameter int DW       = 128,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dcache_sram_arb_if.slave bus
);
    localparam int c_SEL_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int c_CNT_W  = $clog2(LOCK_MAX + 1);

    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE = c_WAIT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_LOCK_MAX = c_CNT_W'(LOCK_MAX);
    // Round-robin pointer starts at the last port so port 1 is searched first.
    localparam logic [c_SEL_W-1:0]  c_RR_RST   = c_SEL_W'(NR_PORTS - 1);

    // LK_COOL: lock just hit LOCK_MAX; r_lk_owner's lock_i is ignored.
    typedef enum logic [1:0] {
        LK_IDLE = 2'd0,
        LK_HELD = 2'd1,
        LK_COOL = 2'd2
    } lock_state_e;

    lock_state_e          r_lk_state;
    lock_state_e          w_lk_state_n;
    logic [c_SEL_W-1:0]   r_lk_owner;
    logic [c_SEL_W-1:0]   w_lk_owner_n;
    logic [c_CNT_W-1:0]   r_lk_cnt;
    logic [c_CNT_W-1:0]   w_lk_cnt_n;
    logic [c_CNT_W-1:0]   w_cnt_next;

    logic [c_SEL_W-1:0]   r_rr;
    logic [c_WAIT_W-1:0]  r_wait [1:NR_PORTS-1];
    logic [NR_PORTS-1:0]  r_rvalid;

    logic                 w_found;
    logic                 w_via_lock;
    logic                 w_any;
    logic                 w_owner_blocked;
    logic [c_SEL_W-1:0]   w_idx;
    logic [NR_PORTS-1:0]  w_gnt;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_wdata;

    // k-th candidate after base in the ring 1..NR_PORTS-1 (port 0 excluded).
    function automatic int rr_pick(input logic [c_SEL_W-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t > NR_PORTS - 1) begin
            t = t - (NR_PORTS - 1);
        end
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Priority selection: first matching rule wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_found    = 1'b0;
        w_idx      = '0;
        w_via_lock = 1'b0;

        // A held lock only wins while the owner keeps both req and lock up;
        // otherwise the lock is released and the lower rules decide.
        if ((r_lk_state == LK_HELD) && bus.req_i[r_lk_owner] && bus.lock_i[r_lk_owner]) begin
            w_found    = 1'b1;
            w_idx      = r_lk_owner;
            w_via_lock = 1'b1;
        end

        for (int p = 1; p < NR_PORTS; p++) begin
            if (!w_found && bus.req_i[p] && (r_wait[p] == c_WAIT_MAX)) begin
                w_found = 1'b1;
                w_idx   = c_SEL_W'(p);
            end
        end

        if (!w_found && bus.req_i[0]) begin
            w_found = 1'b1;
            w_idx   = '0;
        end

        for (int k = 1; k < NR_PORTS; k++) begin
            if (!w_found && bus.req_i[rr_pick(r_rr, k)]) begin
                w_found = 1'b1;
                w_idx   = c_SEL_W'(rr_pick(r_rr, k));
            end
        end

        w_any = w_found && !rst_i;
    end

    // ------------------------------------------------------------------
    // One-hot grant and SRAM request mux (all zero when idle or in reset).
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt   = '0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (w_any && (w_idx == c_SEL_W'(p))) begin
                w_gnt[p] = 1'b1;
                w_we     = bus.we_i[p];
                w_addr   = bus.addr_i[p*AW +: AW];
                w_wdata  = bus.wdata_i[p*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM next state.
    // ------------------------------------------------------------------
    always_comb begin
        w_lk_state_n    = r_lk_state;
        w_lk_owner_n    = r_lk_owner;
        w_lk_cnt_n      = r_lk_cnt;
        w_cnt_next      = c_CNT_ONE;
        w_owner_blocked = (r_lk_state == LK_COOL) && (w_idx == r_lk_owner);

        case (r_lk_state)
            LK_HELD: begin
                if (!w_via_lock) begin
                    w_lk_state_n = LK_IDLE;
                    w_lk_cnt_n   = '0;
                end
            end
            LK_COOL: begin
                // Cooldown ends after an idle cycle or a grant to anyone else.
                if (!w_any || (w_idx != r_lk_owner)) begin
                    w_lk_state_n = LK_IDLE;
                end
            end
            default: ;
        endcase

        if (w_via_lock) begin
            w_cnt_next = r_lk_cnt + c_CNT_ONE;
        end

        // Acquire (count restarts at 1) or continue (count + 1).
        if (w_any && bus.lock_i[w_idx] && !w_owner_blocked) begin
            w_lk_owner_n = w_idx;
            if (w_cnt_next >= c_LOCK_MAX) begin
                w_lk_state_n = LK_COOL;
                w_lk_cnt_n   = '0;
            end else begin
                w_lk_state_n = LK_HELD;
                w_lk_cnt_n   = w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lk_state <= LK_IDLE;
            r_lk_owner <= '0;
            r_lk_cnt   <= '0;
        end else begin
            r_lk_state <= w_lk_state_n;
            r_lk_owner <= w_lk_owner_n;
            r_lk_cnt   <= w_lk_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer, starvation counters, read-return valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr     <= c_RR_RST;
            r_rvalid <= '0;
            for (int p = 1; p < NR_PORTS; p++) begin
                r_wait[p] <= '0;
            end
        end else begin
            r_rvalid <= w_we ? '0 : w_gnt;
            if (w_any && (w_idx != '0)) begin
                r_rr <= w_idx;
            end
            for (int p = 1; p < NR_PORTS; p++) begin
                if (bus.req_i[p] && !w_gnt[p]) begin
                    if (r_wait[p] != c_WAIT_MAX) begin
                        r_wait[p] <= r_wait[p] + c_WAIT_ONE;
                    end
                end else begin
                    r_wait[p] <= '0;
                end
            end
        end
    end

    assign bus.gnt_o        = w_gnt;
    assign bus.sram_req_o   = w_any;
    assign bus.sram_we_o    = w_we;
    assign bus.sram_addr_o  = w_addr;
    assign bus.sram_wdata_o = w_wdata;
    assign bus.sram_sel_o   = w_any ? w_idx : '0;
    // A read return still pending when reset arrives is dropped.
    assign bus.rvalid_o     = rst_i ? '0 : r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dcache_sram_arb.sv
`default_nettype none
// ============================================================================
// Module    : tb_dcache_sram_arb
// Purpose   : Self-checking bench for dcache_sram_arb. Stimulus pushes the
//             reference model's expected outputs into a queue; a negedge
//             monitor pops and compares. Directed scenarios add fixed checks.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_dcache_sram_arb;
    localparam int NP       = 4;
    localparam int AW       = 12;
    localparam int DW       = 128;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 4;

    typedef struct packed {
        logic [NP-1:0] gnt;
        logic [NP-1:0] rv;
        logic          sreq;
        logic          swe;
        logic [AW-1:0] saddr;
        logic [DW-1:0] swd;
        logic [1:0]    ssel;
    } exp_t;

    logic clk;
    logic rst;
    dcache_sram_arb_if #(.NR_PORTS(NP), .AW(AW), .DW(DW)) bus ();

    dcache_sram_arb #(
        .NR_PORTS(NP), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];
    exp_t mon_e;

    // Driven values for the current cycle
    logic          d_rst;
    logic [NP-1:0] d_req, d_we, d_lock;
    logic [AW-1:0] d_addr [NP];
    logic [DW-1:0] d_wd   [NP];

    // Reference model state
    int m_rr;
    int m_wait [NP];
    bit m_lk_on;
    int m_lk_owner;
    int m_lk_cnt;
    bit m_cool;
    int m_cool_port;
    int m_rv;

    logic [NP-1:0] rr_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic rand_data();
        for (int p = 0; p < NP; p++) begin
            d_addr[p] = AW'($urandom);
            d_wd[p]   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic apply();
        rst         = d_rst;
        bus.req_i   = d_req;
        bus.we_i    = d_we;
        bus.lock_i  = d_lock;
        bus.addr_i  = {d_addr[3], d_addr[2], d_addr[1], d_addr[0]};
        bus.wdata_i = {d_wd[3], d_wd[2], d_wd[1], d_wd[0]};
    endtask

    // Behavioural model: returns this cycle's outputs, advances to next cycle.
    task automatic model_cycle(output exp_t e);
        int g;
        int cand;
        int cnt;
        bit by_lock;
        e = '0;
        g = -1;
        by_lock = 1'b0;
        if (d_rst) begin
            m_rr = NP - 1;
            for (int p = 0; p < NP; p++) m_wait[p] = 0;
            m_lk_on = 1'b0;
            m_lk_cnt = 0;
            m_cool = 1'b0;
            m_rv = -1;
            return;
        end
        if (m_rv >= 0) e.rv = NP'(1 << m_rv);

        if (m_lk_on && d_req[m_lk_owner] && d_lock[m_lk_owner]) begin
            g = m_lk_owner;
            by_lock = 1'b1;
        end
        for (int p = 1; p < NP; p++)
            if (g < 0 && d_req[p] && m_wait[p] == MAX_WAIT) g = p;
        if (g < 0 && d_req[0]) g = 0;
        for (int k = 1; k < NP; k++) begin
            cand = (m_rr - 1 + k) % (NP - 1) + 1;
            if (g < 0 && d_req[cand]) g = cand;
        end

        if (g >= 0) begin
            e.gnt   = NP'(1 << g);
            e.sreq  = 1'b1;
            e.swe   = d_we[g];
            e.saddr = d_addr[g];
            e.swd   = d_wd[g];
            e.ssel  = 2'(g);
        end

        for (int p = 1; p < NP; p++)
            m_wait[p] = (d_req[p] && g != p) ? ((m_wait[p] < MAX_WAIT) ? m_wait[p] + 1 : MAX_WAIT) : 0;
        if (g >= 1) m_rr = g;
        m_rv = (g >= 0 && !d_we[g]) ? g : -1;

        if (m_cool && g != m_cool_port) m_cool = 1'b0;
        if (m_lk_on && !by_lock) m_lk_on = 1'b0;
        if (g >= 0 && d_lock[g] && !(m_cool && g == m_cool_port)) begin
            cnt = by_lock ? m_lk_cnt + 1 : 1;
            if (cnt >= LOCK_MAX) begin
                m_lk_on = 1'b0;
                m_cool = 1'b1;
                m_cool_port = g;
            end else begin
                m_lk_on = 1'b1;
                m_lk_owner = g;
                m_lk_cnt = cnt;
            end
        end
    endtask

    task automatic run_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        apply();
        model_cycle(e);
        q.push_back(e);
    endtask

    task automatic idle();
        d_req  = '0;
        d_we   = '0;
        d_lock = '0;
        run_cycle();
    endtask

    // Monitor: compare DUT against the queued model expectation each cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("mon_gnt",        bus.gnt_o,        mon_e.gnt);
            check("mon_rvalid",     bus.rvalid_o,     mon_e.rv);
            check("mon_sram_req",   bus.sram_req_o,   mon_e.sreq);
            check("mon_sram_we",    bus.sram_we_o,    mon_e.swe);
            check("mon_sram_addr",  bus.sram_addr_o,  mon_e.saddr);
            check("mon_sram_wdata", bus.sram_wdata_o, mon_e.swd);
            check("mon_sram_sel",   bus.sram_sel_o,   mon_e.ssel);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        d_rst = 1'b1;
        d_req = '0;
        d_we = '0;
        d_lock = '0;
        rand_data();
        apply();

        // Reset held two cycles with every port requesting
        d_req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            @(negedge clk);
            check("reset_gnt", bus.gnt_o, 4'b0000);
            check("reset_sram_req", bus.sram_req_o, 1'b0);
            check("reset_rvalid", bus.rvalid_o, 4'b0000);
        end
        d_rst = 1'b0;
        run_cycle();
        @(negedge clk);
        check("post_reset_gnt", bus.gnt_o, 4'b0001);

        // Round-robin over ports 1..3 with wrap
        idle();
        d_req = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            @(negedge clk);
            check("rr_gnt", bus.gnt_o, rr_seq[i]);
        end

        // Starvation escalation against port 0
        idle();
        d_req = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            @(negedge clk);
            check("starve_gnt", bus.gnt_o, (i % 5 == 4) ? 4'b0010 : 4'b0001);
        end

        // Lock bounded by LOCK_MAX, port 0 waiting
        idle();
        d_req = 4'b0100;
        d_lock = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) d_req = 4'b0101;
            run_cycle();
            @(negedge clk);
            check("lock_bound_gnt", bus.gnt_o, (i < 4) ? 4'b0100 : 4'b0001);
        end

        // Expired owner granted alone must not re-acquire the lock
        idle();
        d_req = 4'b0100;
        d_lock = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) d_req = 4'b0110;
            run_cycle();
            @(negedge clk);
            check("lock_cool_gnt", bus.gnt_o, (i < 5) ? 4'b0100 : 4'b0010);
        end

        // Read return vs write
        idle();
        rand_data();
        d_addr[3] = 12'h12A;
        d_req = 4'b1000;
        d_we = 4'b0000;
        run_cycle();
        @(negedge clk);
        check("read_gnt", bus.gnt_o, 4'b1000);
        check("read_addr", bus.sram_addr_o, 12'h12A);
        check("read_sel", bus.sram_sel_o, 2'd3);
        check("read_we", bus.sram_we_o, 1'b0);
        idle();
        @(negedge clk);
        check("read_rvalid", bus.rvalid_o, 4'b1000);
        d_req = 4'b1000;
        d_we = 4'b1000;
        run_cycle();
        @(negedge clk);
        check("write_we", bus.sram_we_o, 1'b1);
        idle();
        @(negedge clk);
        check("write_no_rvalid", bus.rvalid_o, 4'b0000);

        // Reset in the middle of a locked read sequence
        idle();
        d_req = 4'b0010;
        d_lock = 4'b0010;
        run_cycle();
        run_cycle();
        @(negedge clk);
        check("midlock_gnt", bus.gnt_o, 4'b0010);
        d_rst = 1'b1;
        d_req = 4'b0011;
        run_cycle();
        @(negedge clk);
        check("midlock_rst_gnt", bus.gnt_o, 4'b0000);
        check("midlock_rst_rvalid", bus.rvalid_o, 4'b0000);
        d_rst = 1'b0;
        run_cycle();
        @(negedge clk);
        check("midlock_post_gnt", bus.gnt_o, 4'b0001);
        check("midlock_post_rvalid", bus.rvalid_o, 4'b0000);

        // Randomized traffic, model-checked by the monitor
        for (int i = 0; i < 500; i++) begin
            d_rst  = ($urandom_range(0, 63) == 0);
            d_req  = NP'($urandom | $urandom);
            d_we   = NP'($urandom);
            d_lock = NP'($urandom | $urandom);
            rand_data();
            run_cycle();
        end
        d_rst = 1'b0;
        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        check("queue_drain", DW'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
